// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
//   Controller in front of the register bank's single write port.
//   After reset it holds rb_start low for CLEAR_CYCLES edges so the bank can
//   clear itself. It then shares the write port between the ALU and the
//   memory-load writeback paths using round-robin valid/ready arbitration.
//   Link (return-address) writes to LINK_REG travel on the bank's separate
//   ra_we/pc_4 path, and any same-cycle ordinary write to LINK_REG yields to them.
//   Every bank control output is registered.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   alu_valid/alu_wr/alu_data   ALU writeback request; alu_ready = granted
//   mem_valid/mem_wr/mem_data   load writeback request; mem_ready = granted
//   link_req/link_pc4           link write of link_pc4 into LINK_REG
//   rb_start, rb_we, rb_wr,     registered register-bank controls
//   rb_data, rb_ra_we, rb_pc_4
//   init_done                   high once the bank clear has finished
//   stall_cnt                   saturating count of cycles with an unserved request
module regbank_write_arbiter #(
  parameter int CLEAR_CYCLES = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LINK_REG     = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_wr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_wr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              link_req,
  input  logic [DATA_W-1:0] link_pc4,
  output logic              rb_start,
  output logic              rb_we,
  output logic [ADDR_W-1:0] rb_wr,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_ra_we,
  output logic [DATA_W-1:0] rb_pc_4,
  output logic              init_done,
  output logic [7:0]        stall_cnt
);

  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               rr_ptr_reg, rr_ptr_next;   // 0 = ALU has priority, 1 = MEM

  logic               rb_start_next, rb_we_next, rb_ra_we_next, init_done_next;
  logic [ADDR_W-1:0]  rb_wr_next;
  logic [DATA_W-1:0]  rb_data_next, rb_pc_4_next;
  logic [7:0]         stall_cnt_next;

  logic               alu_elig, mem_elig, grant_alu, grant_mem;

  // A requester aiming at LINK_REG while a link write is pending must wait,
  // so the link value is never overwritten in the same cycle.
  assign alu_elig = alu_valid && !(link_req && (alu_wr == LINK_ADDR));
  assign mem_elig = mem_valid && !(link_req && (mem_wr == LINK_ADDR));

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    rb_start_next  = rb_start;
    init_done_next = init_done;
    rb_we_next     = 1'b0;
    rb_wr_next     = rb_wr;
    rb_data_next   = rb_data;
    rb_ra_we_next  = 1'b0;
    rb_pc_4_next   = rb_pc_4;
    stall_cnt_next = stall_cnt;
    grant_alu      = 1'b0;
    grant_mem      = 1'b0;

    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next     = RUN;
          cnt_next       = cnt_reg;
          rb_start_next  = 1'b1;
          init_done_next = 1'b1;
        end
      end
      RUN: begin
        grant_alu = alu_elig && (!mem_elig || !rr_ptr_reg);
        grant_mem = mem_elig && (!alu_elig ||  rr_ptr_reg);

        if (grant_alu) begin
          rb_we_next   = 1'b1;
          rb_wr_next   = alu_wr;
          rb_data_next = alu_data;
          rr_ptr_next  = 1'b1;
        end else if (grant_mem) begin
          rb_we_next   = 1'b1;
          rb_wr_next   = mem_wr;
          rb_data_next = mem_data;
          rr_ptr_next  = 1'b0;
        end

        rb_ra_we_next = link_req;
        if (link_req) rb_pc_4_next = link_pc4;

        if (((alu_valid && !grant_alu) || (mem_valid && !grant_mem)) &&
            (stall_cnt != 8'hFF))
          stall_cnt_next = stall_cnt + 8'd1;
      end
      default: state_next = INIT;
    endcase
  end

  // Ready is the grant itself: it depends only on state, valids, addresses and link_req.
  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= INIT;
      cnt_reg    <= '0;
      rr_ptr_reg <= 1'b0;
      rb_start   <= 1'b0;
      rb_we      <= 1'b0;
      rb_wr      <= '0;
      rb_data    <= '0;
      rb_ra_we   <= 1'b0;
      rb_pc_4    <= '0;
      init_done  <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rr_ptr_reg <= rr_ptr_next;
      rb_start   <= rb_start_next;
      rb_we      <= rb_we_next;
      rb_wr      <= rb_wr_next;
      rb_data    <= rb_data_next;
      rb_ra_we   <= rb_ra_we_next;
      rb_pc_4    <= rb_pc_4_next;
      init_done  <= init_done_next;
      stall_cnt  <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed testbench for regbank_write_arbiter. Inputs change on the falling
// edge; ready is sampled 1ns later, and registered outputs are sampled at the
// next falling edge.
module tb_regbank_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_wr = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_wr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        link_req = 1'b0;
  logic [31:0] link_pc4 = '0;
  logic        rb_start, rb_we, rb_ra_we, init_done;
  logic [4:0]  rb_wr;
  logic [31:0] rb_data, rb_pc_4;
  logic [7:0]  stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  regbank_write_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_wr(alu_wr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_data(mem_data), .mem_ready(mem_ready),
    .link_req(link_req), .link_pc4(link_pc4),
    .rb_start(rb_start), .rb_we(rb_we), .rb_wr(rb_wr), .rb_data(rb_data),
    .rb_ra_we(rb_ra_we), .rb_pc_4(rb_pc_4), .init_done(init_done), .stall_cnt(stall_cnt)
  );

  task automatic clear_inputs();
    alu_valid = 1'b0; alu_wr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_wr = '0; mem_data = '0;
    link_req  = 1'b0; link_pc4 = '0;
  endtask

  // Reset, release and wait out the two clear cycles (no checks here).
  task automatic reset_to_run();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({rb_start, rb_we, rb_ra_we, init_done} !== 4'b0000)
      $display("FAIL reset_ctrl: got start/we/ra_we/done=%b want 0000", {rb_start, rb_we, rb_ra_we, init_done});
    else pass_cnt++;
    total_cnt++;
    if ({rb_wr, rb_data, rb_pc_4, stall_cnt} !== '0)
      $display("FAIL reset_data: got wr=%0d data=%h pc4=%h stall=%0d want all 0", rb_wr, rb_data, rb_pc_4, stall_cnt);
    else pass_cnt++;

    // Release and present a request during INIT.
    rst = 1'b0;
    alu_valid = 1'b1; alu_wr = 5'd1; alu_data = 32'h1;
    #1;
    total_cnt++;
    if (alu_ready !== 1'b0) $display("FAIL init_ready: got %b want 0", alu_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rb_start !== 1'b0 || init_done !== 1'b0)
      $display("FAIL init_edge1: got start=%b done=%b want 0 0", rb_start, init_done);
    else pass_cnt++;
    total_cnt++;
    if (alu_ready !== 1'b0 || rb_we !== 1'b0)
      $display("FAIL init_edge1_ready: got ready=%b we=%b want 0 0", alu_ready, rb_we);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rb_start !== 1'b1 || init_done !== 1'b1)
      $display("FAIL init_edge2: got start=%b done=%b want 1 1", rb_start, init_done);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 8'd0 || rb_we !== 1'b0)
      $display("FAIL init_stall: got stall=%0d we=%b want 0 0", stall_cnt, rb_we);
    else pass_cnt++;
    clear_inputs();
    $display("reset: rb_start=%b init_done=%b after 2 edges", rb_start, init_done);
  endtask

  task automatic test_alu_single();
    alu_valid = 1'b1; alu_wr = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0)
      $display("FAIL alu_ready: got alu=%b mem=%b want 1 0", alu_ready, mem_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rb_we !== 1'b1 || rb_wr !== 5'd5 || rb_data !== 32'hDEADBEEF)
      $display("FAIL alu_write: got we=%b wr=%0d data=%h want 1 5 deadbeef", rb_we, rb_wr, rb_data);
    else pass_cnt++;
    clear_inputs();
    @(negedge clk);
    total_cnt++;
    if (rb_we !== 1'b0 || rb_wr !== 5'd5 || rb_data !== 32'hDEADBEEF)
      $display("FAIL alu_idle: got we=%b wr=%0d data=%h want 0 5 deadbeef", rb_we, rb_wr, rb_data);
    else pass_cnt++;
    $display("alu_single: wr=%0d data=%h", rb_wr, rb_data);
  endtask

  task automatic test_round_robin();
    logic       exp_alu;
    logic [4:0] exp_wr;
    reset_to_run();
    alu_valid = 1'b1; alu_wr = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_wr = 5'd4; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      exp_wr  = exp_alu ? 5'd3 : 5'd4;
      #1;
      total_cnt++;
      if (alu_ready !== exp_alu || mem_ready !== !exp_alu)
        $display("FAIL rr_ready%0d: got alu=%b mem=%b want %b %b", i, alu_ready, mem_ready, exp_alu, !exp_alu);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (rb_we !== 1'b1 || rb_wr !== exp_wr || rb_data !== (exp_alu ? 32'h11 : 32'h22))
        $display("FAIL rr_write%0d: got we=%b wr=%0d data=%h want 1 %0d", i, rb_we, rb_wr, rb_data, exp_wr);
      else pass_cnt++;
      $display("rr: cycle %0d granted %s wr=%0d", i, exp_alu ? "ALU" : "MEM", rb_wr);
    end
    clear_inputs();
    total_cnt++;
    if (stall_cnt !== 8'd4) $display("FAIL rr_stall: got %0d want 4", stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_link_conflict();
    link_req = 1'b1; link_pc4 = 32'h40;
    alu_valid = 1'b1; alu_wr = 5'd31; alu_data = 32'h55;
    #1;
    total_cnt++;
    if (alu_ready !== 1'b0) $display("FAIL link_block_ready: got %b want 0", alu_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rb_ra_we !== 1'b1 || rb_pc_4 !== 32'h40 || rb_we !== 1'b0)
      $display("FAIL link_write: got ra_we=%b pc4=%h we=%b want 1 40 0", rb_ra_we, rb_pc_4, rb_we);
    else pass_cnt++;
    link_req = 1'b0; link_pc4 = 32'h0;
    #1;
    total_cnt++;
    if (alu_ready !== 1'b1) $display("FAIL link_retry_ready: got %b want 1", alu_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rb_we !== 1'b1 || rb_wr !== 5'd31 || rb_data !== 32'h55 || rb_ra_we !== 1'b0 || rb_pc_4 !== 32'h40)
      $display("FAIL link_retry_write: got we=%b wr=%0d data=%h ra_we=%b pc4=%h want 1 31 55 0 40",
               rb_we, rb_wr, rb_data, rb_ra_we, rb_pc_4);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 8'd5) $display("FAIL link_stall: got %0d want 5", stall_cnt);
    else pass_cnt++;
    clear_inputs();
    $display("link_conflict: pc4=%h then ALU wr=%0d", rb_pc_4, rb_wr);
  endtask

  task automatic test_link_parallel();
    link_req = 1'b1; link_pc4 = 32'h80;
    mem_valid = 1'b1; mem_wr = 5'd7; mem_data = 32'h99;
    #1;
    total_cnt++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0)
      $display("FAIL par_ready: got mem=%b alu=%b want 1 0", mem_ready, alu_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rb_ra_we !== 1'b1 || rb_pc_4 !== 32'h80 || rb_we !== 1'b1 || rb_wr !== 5'd7 || rb_data !== 32'h99)
      $display("FAIL par_write: got ra_we=%b pc4=%h we=%b wr=%0d data=%h want 1 80 1 7 99",
               rb_ra_we, rb_pc_4, rb_we, rb_wr, rb_data);
    else pass_cnt++;
    clear_inputs();
    $display("link_parallel: pc4=%h mem wr=%0d", rb_pc_4, rb_wr);
  endtask

  task automatic test_saturation_and_reset();
    link_req = 1'b1; link_pc4 = 32'hC0;
    alu_valid = 1'b1; alu_wr = 5'd31; alu_data = 32'h77;
    for (int i = 0; i < 300; i++) @(negedge clk);
    total_cnt++;
    if (stall_cnt !== 8'd255) $display("FAIL stall_sat: got %0d want 255", stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (rb_ra_we !== 1'b1 || rb_pc_4 !== 32'hC0 || rb_we !== 1'b0)
      $display("FAIL sat_link: got ra_we=%b pc4=%h we=%b want 1 c0 0", rb_ra_we, rb_pc_4, rb_we);
    else pass_cnt++;
    $display("saturation: stall_cnt=%0d", stall_cnt);

    // Asynchronous reset mid-run, away from any clock edge.
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({rb_start, rb_we, rb_ra_we, init_done} !== 4'b0000 || stall_cnt !== 8'd0 || rb_pc_4 !== 32'd0)
      $display("FAIL midrun_reset: got start=%b we=%b ra_we=%b done=%b stall=%0d pc4=%h want all 0",
               rb_start, rb_we, rb_ra_we, init_done, stall_cnt, rb_pc_4);
    else pass_cnt++;
    total_cnt++;
    if (alu_ready !== 1'b0) $display("FAIL midrun_ready: got %b want 0", alu_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    total_cnt++;
    if (rb_start !== 1'b0) $display("FAIL rerun_edge1: got start=%b want 0", rb_start);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rb_start !== 1'b1 || init_done !== 1'b1)
      $display("FAIL rerun_edge2: got start=%b done=%b want 1 1", rb_start, init_done);
    else pass_cnt++;
    $display("midrun_reset: back to RUN start=%b", rb_start);
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_round_robin();
    test_link_conflict();
    test_link_parallel();
    test_saturation_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
